// File: rtl/stat_seg7_display.sv
// rtl/stat_seg7_display.sv - event statistics counters with 8-digit hex seven-segment scanner (optional LEAD_ZERO_BLANK_EN)
module stat_seg7_display #(
    parameter int NUM_CH   = 3,
    parameter int CNT_W    = 32,
    parameter int SEL_W    = 3,
    parameter int SCAN_DIV = 100000,
    parameter bit SATURATE = 1'b0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [NUM_CH-1:0] evt_inc,
    input  logic [NUM_CH-1:0] cnt_clr,
    input  logic              halt,
    input  logic [SEL_W-1:0]  sel,
    input  logic [31:0]       ext_data,
    output logic [NUM_CH-1:0] ovf,
    output logic [7:0]        SEG,
    output logic [7:0]        AN
);

    localparam int PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] cnt [NUM_CH];
    logic [PRE_W-1:0] pre;
    logic             pre_wrap;
    logic [2:0]       d;
    logic [31:0]      snap;
    logic             dash;
    logic [31:0]      src;
    logic             src_dash;
    logic [3:0]       nib;
    logic [7:0]       seg_next;
`ifdef LEAD_ZERO_BLANK_EN
    logic [2:0]       top;
`endif

    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_seg = 8'hC0;
            4'h1: hex_seg = 8'hF9;
            4'h2: hex_seg = 8'hA4;
            4'h3: hex_seg = 8'hB0;
            4'h4: hex_seg = 8'h99;
            4'h5: hex_seg = 8'h92;
            4'h6: hex_seg = 8'h82;
            4'h7: hex_seg = 8'hF8;
            4'h8: hex_seg = 8'h80;
            4'h9: hex_seg = 8'h90;
            4'hA: hex_seg = 8'h88;
            4'hB: hex_seg = 8'h83;
            4'hC: hex_seg = 8'hC6;
            4'hD: hex_seg = 8'hA1;
            4'hE: hex_seg = 8'h86;
            default: hex_seg = 8'h8E;
        endcase
    endfunction

    assign pre_wrap = (pre == PRE_W'(SCAN_DIV - 1));

    // Event counters: per-channel clear beats increment; halt freezes increments only
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
            ovf <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cnt_clr[i]) begin
                    cnt[i] <= '0;
                    ovf[i] <= 1'b0;
                end else if (evt_inc[i] && !halt) begin
                    if (cnt[i] == {CNT_W{1'b1}}) begin
                        ovf[i] <= 1'b1;
                        if (!SATURATE) cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Prescaler and digit index: one digit step every SCAN_DIV cycles
    always_ff @(posedge clk) begin
        if (clr) begin
            pre <= '0;
            d   <= 3'd0;
        end else if (pre_wrap) begin
            pre <= '0;
            d   <= (d == 3'd7) ? 3'd0 : d + 3'd1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Source select: counter, external word, or dash frame for out-of-range sel
    always_comb begin
        src      = ext_data;
        src_dash = 1'b0;
        if (sel > SEL_W'(NUM_CH)) begin
            src_dash = 1'b1;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sel == SEL_W'(i)) src = 32'(cnt[i]);
            end
        end
    end

    // Frame snapshot taken only at scan start so a frame never mixes sources
    always_ff @(posedge clk) begin
        if (clr) begin
            snap <= 32'h0;
            dash <= 1'b0;
        end else if (pre_wrap && d == 3'd7) begin
            snap <= src;
            dash <= src_dash;
        end
    end

    // Segment pattern for the current digit of the snapshot
    always_comb begin
        nib      = snap[{d, 2'b00} +: 4];
        seg_next = dash ? 8'hBF : hex_seg(nib);
`ifdef LEAD_ZERO_BLANK_EN
        top = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (snap[4*k +: 4] != 4'h0) top = 3'(k);
        end
        if (!dash && d > top) seg_next = 8'hFF;
`endif
    end

    // Registered display drive, one cycle behind the digit index
    always_ff @(posedge clk) begin
        if (clr) begin
            SEG <= 8'hC0;
            AN  <= 8'hFE;
        end else begin
            SEG <= seg_next;
            AN  <= ~(8'h01 << d);
        end
    end

endmodule

// File: tb/tb_stat_seg7_display.sv
// tb/tb_stat_seg7_display.sv - directed self-checking bench for stat_seg7_display
module tb_stat_seg7_display;

    logic        clk = 1'b0;
    logic        clr;
    logic [2:0]  evt_inc;
    logic [2:0]  cnt_clr;
    logic        halt;
    logic [2:0]  sel;
    logic [31:0] ext_data;
    logic [2:0]  ovf_a, ovf_w, ovf_s;
    logic [7:0]  seg_a, an_a, seg_w, an_w, seg_s, an_s;

    int checks = 0;
    int errors = 0;

    logic [7:0] fa [8];
    logic [7:0] fw [8];
    logic [7:0] fs [8];

    always #5 clk = ~clk;

    stat_seg7_display #(.NUM_CH(3), .CNT_W(32), .SEL_W(3), .SCAN_DIV(4), .SATURATE(1'b0)) dut (
        .clk(clk), .clr(clr), .evt_inc(evt_inc), .cnt_clr(cnt_clr), .halt(halt),
        .sel(sel), .ext_data(ext_data), .ovf(ovf_a), .SEG(seg_a), .AN(an_a));

    stat_seg7_display #(.NUM_CH(3), .CNT_W(8), .SEL_W(3), .SCAN_DIV(4), .SATURATE(1'b0)) dut_w (
        .clk(clk), .clr(clr), .evt_inc(evt_inc), .cnt_clr(cnt_clr), .halt(halt),
        .sel(sel), .ext_data(ext_data), .ovf(ovf_w), .SEG(seg_w), .AN(an_w));

    stat_seg7_display #(.NUM_CH(3), .CNT_W(8), .SEL_W(3), .SCAN_DIV(4), .SATURATE(1'b1)) dut_s (
        .clk(clk), .clr(clr), .evt_inc(evt_inc), .cnt_clr(cnt_clr), .halt(halt),
        .sel(sel), .ext_data(ext_data), .ovf(ovf_s), .SEG(seg_s), .AN(an_s));

    function automatic logic [7:0] hexseg(input logic [3:0] n);
        logic [7:0] tbl [16];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return tbl[n];
    endfunction

    function automatic logic [7:0] exp_digit(input logic [31:0] v, input int k);
        logic [3:0] nib;
        nib = v[4*k +: 4];
`ifdef LEAD_ZERO_BLANK_EN
        begin
            int top;
            top = 0;
            for (int j = 0; j < 8; j++) if (v[4*j +: 4] != 4'h0) top = j;
            if (k > top) return 8'hFF;
        end
`endif
        return hexseg(nib);
    endfunction

    task automatic wait_boundary();
        int t;
        t = 0;
        while (an_a !== 8'h7F && t < 100) begin @(negedge clk); t++; end
        while (an_a !== 8'hFE && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin
            checks++; errors++;
            $display("FAIL frame_boundary timeout AN=%h", an_a);
        end
    endtask

    task automatic capture(input bit do_wait);
        int t;
        logic [7:0] want;
        if (do_wait) wait_boundary();
        for (int k = 0; k < 8; k++) begin
            want = ~(8'h01 << k);
            t = 0;
            while (an_a !== want && t < 20) begin @(negedge clk); t++; end
            if (t >= 20) begin
                checks++; errors++;
                $display("FAIL digit_scan timeout AN=%h want %h", an_a, want);
            end
            fa[k] = seg_a; fw[k] = seg_w; fs[k] = seg_s;
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        @(negedge clk);
        checks++; if (an_a !== 8'hFE) begin errors++; $display("FAIL reset_an got %h want fe", an_a); end
        checks++; if (seg_a !== 8'hC0) begin errors++; $display("FAIL reset_seg got %h want c0", seg_a); end
        checks++; if (ovf_a !== 3'b000) begin errors++; $display("FAIL reset_ovf got %b want 000", ovf_a); end
        clr = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (an_a !== 8'hFE) begin errors++; $display("FAIL an_lag got %h want fe", an_a); end
        @(negedge clk);
        checks++; if (an_a !== 8'hFD) begin errors++; $display("FAIL an_step got %h want fd", an_a); end
        checks++; if (seg_a !== exp_digit(32'h0, 1)) begin
            errors++; $display("FAIL seg_digit1 got %h want %h", seg_a, exp_digit(32'h0, 1)); end
    endtask

    task automatic test_count();
        sel = 3'd1;
        evt_inc[1] = 1'b1;
        repeat (10) @(negedge clk);
        evt_inc[1] = 1'b0;
        wait_boundary();
        capture(1'b1);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (fa[k] !== exp_digit(32'hA, k)) begin
                errors++; $display("FAIL count10_digit%0d got %h want %h", k, fa[k], exp_digit(32'hA, k));
            end
        end
        checks++; if (fa[0] !== 8'h88) begin errors++; $display("FAIL count10_d0 got %h want 88", fa[0]); end
        checks++; if (ovf_a !== 3'b000) begin errors++; $display("FAIL count10_ovf got %b want 000", ovf_a); end
    endtask

    task automatic test_clr_priority();
        evt_inc[0] = 1'b1;
        repeat (5) @(negedge clk);
        cnt_clr[0] = 1'b1;
        @(negedge clk);
        evt_inc[0] = 1'b0;
        cnt_clr[0] = 1'b0;
        checks++; if (ovf_a[0] !== 1'b0) begin errors++; $display("FAIL clr_prio_ovf got %b want 0", ovf_a[0]); end
        evt_inc[2] = 1'b1;
        repeat (3) @(negedge clk);
        halt = 1'b1;
        repeat (20) @(negedge clk);
        halt = 1'b0;
        evt_inc[2] = 1'b0;
        sel = 3'd0;
        wait_boundary();
        capture(1'b1);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (fa[k] !== exp_digit(32'h0, k)) begin
                errors++; $display("FAIL clr_prio_digit%0d got %h want %h", k, fa[k], exp_digit(32'h0, k));
            end
        end
        sel = 3'd2;
        wait_boundary();
        capture(1'b1);
        checks++; if (fa[0] !== 8'hB0) begin errors++; $display("FAIL halt_count got %h want b0", fa[0]); end
        checks++; if (fa[1] !== exp_digit(32'h3, 1)) begin
            errors++; $display("FAIL halt_digit1 got %h want %h", fa[1], exp_digit(32'h3, 1)); end
    endtask

    task automatic test_wrap();
        cnt_clr[2] = 1'b1;
        @(negedge clk);
        cnt_clr[2] = 1'b0;
        sel = 3'd2;
        evt_inc[2] = 1'b1;
        repeat (255) @(negedge clk);
        checks++; if (ovf_w[2] !== 1'b0) begin errors++; $display("FAIL wrap255_ovf got %b want 0", ovf_w[2]); end
        checks++; if (ovf_s[2] !== 1'b0) begin errors++; $display("FAIL sat255_ovf got %b want 0", ovf_s[2]); end
        @(negedge clk);
        evt_inc[2] = 1'b0;
        checks++; if (ovf_w[2] !== 1'b1) begin errors++; $display("FAIL wrap256_ovf got %b want 1", ovf_w[2]); end
        checks++; if (ovf_s[2] !== 1'b1) begin errors++; $display("FAIL sat256_ovf got %b want 1", ovf_s[2]); end
        checks++; if (ovf_a[2] !== 1'b0) begin errors++; $display("FAIL wide256_ovf got %b want 0", ovf_a[2]); end
        wait_boundary();
        capture(1'b1);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (fa[k] !== exp_digit(32'h100, k)) begin
                errors++; $display("FAIL wide_digit%0d got %h want %h", k, fa[k], exp_digit(32'h100, k)); end
            checks++;
            if (fw[k] !== exp_digit(32'h0, k)) begin
                errors++; $display("FAIL wrap_digit%0d got %h want %h", k, fw[k], exp_digit(32'h0, k)); end
            checks++;
            if (fs[k] !== exp_digit(32'hFF, k)) begin
                errors++; $display("FAIL sat_digit%0d got %h want %h", k, fs[k], exp_digit(32'hFF, k)); end
        end
    endtask

    task automatic test_ext_dash();
        logic [7:0] want [8];
        want = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        sel = 3'd3;
        ext_data = 32'h1234ABCD;
        wait_boundary();
        capture(1'b1);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (fa[k] !== want[k]) begin
                errors++; $display("FAIL ext_digit%0d got %h want %h", k, fa[k], want[k]); end
        end
        wait_boundary();
        sel = 3'd7;
        capture(1'b0);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (fa[k] !== want[k]) begin
                errors++; $display("FAIL no_tear_digit%0d got %h want %h", k, fa[k], want[k]); end
        end
        capture(1'b1);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (fa[k] !== 8'hBF) begin
                errors++; $display("FAIL dash_digit%0d got %h want bf", k, fa[k]); end
        end
    endtask

    task automatic test_clr_mid();
        int t;
        evt_inc[0] = 1'b1;
        repeat (4) @(negedge clk);
        evt_inc[0] = 1'b0;
        t = 0;
        while (an_a !== 8'hDF && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) begin checks++; errors++; $display("FAIL clr_mid timeout AN=%h", an_a); end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++; if (an_a !== 8'hFE) begin errors++; $display("FAIL clr_mid_an got %h want fe", an_a); end
        checks++; if (seg_a !== 8'hC0) begin errors++; $display("FAIL clr_mid_seg got %h want c0", seg_a); end
        checks++; if (ovf_w !== 3'b000) begin errors++; $display("FAIL clr_mid_ovf_w got %b want 000", ovf_w); end
        checks++; if (ovf_s !== 3'b000) begin errors++; $display("FAIL clr_mid_ovf_s got %b want 000", ovf_s); end
        sel = 3'd0;
        wait_boundary();
        capture(1'b1);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (fa[k] !== exp_digit(32'h0, k)) begin
                errors++; $display("FAIL clr_mid_digit%0d got %h want %h", k, fa[k], exp_digit(32'h0, k)); end
        end
    endtask

    initial begin
        clr = 1'b1;
        evt_inc = 3'b000;
        cnt_clr = 3'b000;
        halt = 1'b0;
        sel = 3'd0;
        ext_data = 32'h0;
        @(negedge clk);
        test_reset();
        test_count();
        test_clr_priority();
        test_wrap();
        test_ext_dash();
        test_clr_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
